// File: rtl/packet_pkg.sv
// Shared constants and beat payload type for the filter RX ingress path.
package packet_pkg;

    localparam int unsigned ARB_MAX_PORTS = 8;
    localparam int unsigned ARB_TAG_WIDTH = 8;
    localparam int unsigned AXIS_DATA_W   = 512;
    localparam int unsigned AXIS_KEEP_W   = 64;
    localparam int unsigned AXIS_USER_W   = 48;
    localparam int unsigned PKT_CNT_W     = 32;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [AXIS_USER_W-1:0] tuser;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic [AXIS_DATA_W-1:0] tdata;
        logic                   tlast;
    } axis_beat_t;

endpackage

// File: rtl/rr_arb_select.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
module rr_arb_select #(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     grant,
    output logic                 any_req
);

    logic [IDX_W-1:0] idx;

    // Walk from farthest to nearest offset so the nearest requester wins.
    always_comb begin
        grant   = last_grant;
        any_req = |req;
        idx     = '0;
        for (int i = int'(NUM_PORTS); i >= 1; i--) begin
            idx = IDX_W'((int'(last_grant) + i) % int'(NUM_PORTS));
            if (req[idx]) begin
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/rx_pkt_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS AXI-Stream ingress ports into one
// registered stream, tagging tuser with the source port and counting packets.
module rx_pkt_arbiter
    import packet_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 2,
    parameter  int unsigned TAG_LSB   = 40,
    localparam int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    input  logic [NUM_PORTS*AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*AXIS_USER_W-1:0] s_axis_tuser,
    output logic                             m_axis_tvalid,
    output logic [AXIS_DATA_W-1:0]           m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0]           m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic [AXIS_USER_W-1:0]           m_axis_tuser,
    input  logic                             m_axis_tready,
    output logic [IDX_W-1:0]                 grant_idx,
    output logic [NUM_PORTS*PKT_CNT_W-1:0]   port_pkt_count
);

    arb_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              grant_q, last_grant_q, sel_idx;
    logic                          any_req;
    logic                          can_accept, beat_acc, pkt_done;
    axis_beat_t                    beat_in, out_q;
    logic                          out_valid_q;
    logic [NUM_PORTS*PKT_CNT_W-1:0] pkt_count_q;

    rr_arb_select #(.NUM_PORTS(NUM_PORTS)) u_sel (
        .req        (s_axis_tvalid),
        .last_grant (last_grant_q),
        .grant      (sel_idx),
        .any_req    (any_req)
    );

    // Ready only for the owner, and only when the output stage can take a beat.
    assign can_accept = aresetn && (state_q == ARB_LOCKED) && (!out_valid_q || m_axis_tready);
    assign beat_acc   = can_accept && s_axis_tvalid[grant_q];
    assign pkt_done   = beat_acc && beat_in.tlast;

    always_comb begin
        s_axis_tready          = '0;
        s_axis_tready[grant_q] = can_accept;
    end

    // Mux the owner's beat and stamp its port index into tuser.
    always_comb begin
        beat_in.tdata = s_axis_tdata[grant_q*AXIS_DATA_W +: AXIS_DATA_W];
        beat_in.tkeep = s_axis_tkeep[grant_q*AXIS_KEEP_W +: AXIS_KEEP_W];
        beat_in.tuser = s_axis_tuser[grant_q*AXIS_USER_W +: AXIS_USER_W];
        beat_in.tlast = s_axis_tlast[grant_q];
        beat_in.tuser[TAG_LSB +: ARB_TAG_WIDTH] = ARB_TAG_WIDTH'(grant_q);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (any_req)  state_d = ARB_LOCKED;
            ARB_LOCKED: if (pkt_done) state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            if ((state_q == ARB_IDLE) && any_req) begin
                grant_q <= sel_idx;
            end
            if (pkt_done) begin
                last_grant_q <= grant_q;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
        end else if (beat_acc) begin
            out_valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Payload needs no reset; it is qualified by out_valid_q.
    always_ff @(posedge aclk) begin
        if (beat_acc) begin
            out_q <= beat_in;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            pkt_count_q <= '0;
        end else if (pkt_done) begin
            pkt_count_q[grant_q*PKT_CNT_W +: PKT_CNT_W] <=
                pkt_count_q[grant_q*PKT_CNT_W +: PKT_CNT_W] + PKT_CNT_W'(1);
        end
    end

    assign m_axis_tvalid  = out_valid_q;
    assign m_axis_tdata   = out_q.tdata;
    assign m_axis_tkeep   = out_q.tkeep;
    assign m_axis_tlast   = out_q.tlast;
    assign m_axis_tuser   = out_q.tuser;
    assign grant_idx      = grant_q;
    assign port_pkt_count = pkt_count_q;

endmodule

// File: tb/tb_rx_pkt_arbiter.sv
// Directed bench for rx_pkt_arbiter: queue-fed port sources, output beat log,
// hand-computed expected beat order, counts and stall/reset behaviour.
module tb_rx_pkt_arbiter;

    localparam int NP = 2;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [1:0]     s_valid, s_last, s_ready;
    logic [1023:0]  s_data;
    logic [127:0]   s_keep;
    logic [95:0]    s_user;
    logic           m_valid, m_last, m_ready;
    logic [511:0]   m_data;
    logic [63:0]    m_keep;
    logic [47:0]    m_user;
    logic           grant;
    logic [63:0]    cnt;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [7:0]  gap;
    } beat_t;

    beat_t       srcq [NP][$];
    bit          loaded [NP];
    int          gcnt [NP];
    bit          fired [NP];
    bit          src_flush;
    logic [63:0] outq [$];
    int          outc [$];
    int          cyc;
    int          n_cmp, n_err;

    always #5 aclk = ~aclk;

    rx_pkt_arbiter dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis_tvalid  (s_valid),
        .s_axis_tlast   (s_last),
        .s_axis_tready  (s_ready),
        .s_axis_tdata   (s_data),
        .s_axis_tkeep   (s_keep),
        .s_axis_tuser   (s_user),
        .m_axis_tvalid  (m_valid),
        .m_axis_tdata   (m_data),
        .m_axis_tkeep   (m_keep),
        .m_axis_tlast   (m_last),
        .m_axis_tuser   (m_user),
        .m_axis_tready  (m_ready),
        .grant_idx      (grant),
        .port_pkt_count (cnt)
    );

    function automatic logic [31:0] dword(input int p, input int pkt, input int b);
        return {8'(p), 8'(pkt), 8'(b), 8'h5A};
    endfunction

    // Record layout: {7'b0, last, tkeep[7:0], tuser[47:40], tuser[7:0], tdata[31:0]}
    function automatic logic [63:0] erec(input int p, input int pkt, input int b, input bit last);
        return {7'b0, last, 8'(8'h10 + p), 8'(p), 8'(p + 1), dword(p, pkt, b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int i, input logic [63:0] exp);
        logic [63:0] obs;
        obs = (i < outq.size()) ? outq[i] : 64'hDEAD_DEAD_DEAD_DEAD;
        chk($sformatf("%s[%0d]", tag, i), obs, exp);
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (outq.size() < n && k < budget) begin
            @(negedge aclk);
            k++;
        end
        chk({tag, "_beats"}, 64'(outq.size()), 64'(n));
    endtask

    task automatic push_pkt(input int p, input int pkt, input int nb, input int gap_at, input int gap_len);
        for (int b = 0; b < nb; b++) begin
            beat_t x;
            x.data = dword(p, pkt, b);
            x.last = (b == nb - 1);
            x.gap  = (b == gap_at) ? 8'(gap_len) : 8'd0;
            srcq[p].push_back(x);
        end
    endtask

    // Port sources: present queued beats after each edge, sample handshakes late in the cycle.
    initial begin
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        forever begin
            @(posedge aclk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (src_flush) begin
                    srcq[p].delete();
                    loaded[p] = 1'b0;
                    fired[p]  = 1'b0;
                end
                if (fired[p]) begin
                    void'(srcq[p].pop_front());
                    loaded[p] = 1'b0;
                end
                if (!loaded[p] && srcq[p].size() > 0) begin
                    gcnt[p]   = int'(srcq[p][0].gap);
                    loaded[p] = 1'b1;
                end
                if (loaded[p] && gcnt[p] == 0) begin
                    s_valid[p]             = 1'b1;
                    s_last[p]              = srcq[p][0].last;
                    s_data[p*512 +: 512]   = 512'(srcq[p][0].data);
                end else begin
                    s_valid[p] = 1'b0;
                    s_last[p]  = 1'b0;
                    if (loaded[p]) gcnt[p]--;
                end
            end
            @(negedge aclk);
            #2;
            for (int p = 0; p < NP; p++) begin
                fired[p] = s_valid[p] && s_ready[p];
            end
        end
    end

    // Output log of every beat taken by the downstream side.
    initial begin
        cyc = 0;
        forever begin
            @(posedge aclk);
            cyc++;
            #7;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                outq.push_back({7'b0, m_last, m_keep[7:0], m_user[47:40], m_user[7:0], m_data[31:0]});
                outc.push_back(cyc);
            end
        end
    end

    initial begin
        int c0;
        int nlast;
        n_cmp     = 0;
        n_err     = 0;
        src_flush = 1'b0;
        aresetn   = 1'b0;
        m_ready   = 1'b1;
        for (int p = 0; p < NP; p++) begin
            s_keep[p*64 +: 64] = 64'(8'h10 + p);
            s_user[p*48 +: 48] = {8'hA5, 32'h0, 8'(p + 1)};
        end

        // Reset values
        repeat (3) @(negedge aclk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_grant",   64'(grant),   64'd0);
        chk("rst_counts",  cnt,          64'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Simultaneous 3-beat packets: port 0 first, one idle cycle, then port 1
        c0 = cyc;
        push_pkt(0, 8'h10, 3, -1, 0);
        push_pkt(1, 8'h11, 3, -1, 0);
        wait_out("t1", 6, 40);
        for (int b = 0; b < 3; b++) chk_out("t1_p0", b,     erec(0, 8'h10, b, b == 2));
        for (int b = 0; b < 3; b++) chk_out("t1_p1", b + 3, erec(1, 8'h11, b, b == 2));
        chk("t1_latency", 64'(outc[0] - c0), 64'd3);
        chk("t1_gap",     64'(outc[3] - outc[2]), 64'd2);
        chk("t1_counts",  cnt, {32'd1, 32'd1});
        outq.delete(); outc.delete();
        @(negedge aclk);

        // Port 1 streams single-beat packets; port 0 joins one cycle later
        push_pkt(1, 8'h20, 1, -1, 0);
        push_pkt(1, 8'h21, 1, -1, 0);
        push_pkt(1, 8'h22, 1, -1, 0);
        @(negedge aclk);
        push_pkt(0, 8'h23, 1, -1, 0);
        wait_out("t2", 4, 40);
        chk_out("t2", 0, erec(1, 8'h20, 0, 1'b1));
        chk_out("t2", 1, erec(0, 8'h23, 0, 1'b1));
        chk_out("t2", 2, erec(1, 8'h21, 0, 1'b1));
        chk_out("t2", 3, erec(1, 8'h22, 0, 1'b1));
        chk("t2_counts", cnt, {32'd4, 32'd2});
        outq.delete(); outc.delete();
        @(negedge aclk);

        // Owner (port 0) drops tvalid for 3 cycles while port 1 waits
        push_pkt(0, 8'h30, 4, 2, 3);
        push_pkt(1, 8'h31, 2, -1, 0);
        wait_out("t4", 6, 50);
        for (int b = 0; b < 4; b++) chk_out("t4_p0", b,     erec(0, 8'h30, b, b == 3));
        for (int b = 0; b < 2; b++) chk_out("t4_p1", b + 4, erec(1, 8'h31, b, b == 1));
        chk("t4_counts", cnt, {32'd5, 32'd3});
        outq.delete(); outc.delete();
        @(negedge aclk);

        // Downstream stall of 5 cycles with the first beat held on the output
        push_pkt(0, 8'h40, 4, -1, 0);
        begin
            int k;
            k = 0;
            while (m_valid !== 1'b1 && k < 10) begin
                @(negedge aclk);
                k++;
            end
        end
        chk("t3_first_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk($sformatf("t3_hold_valid%0d", i), 64'(m_valid), 64'd1);
            chk($sformatf("t3_hold_data%0d", i),  64'(m_data[31:0]), 64'(dword(0, 8'h40, 0)));
            chk($sformatf("t3_hold_ready%0d", i), 64'(s_ready), 64'd0);
        end
        chk("t3_none_taken", 64'(outq.size()), 64'd0);
        m_ready = 1'b1;
        wait_out("t3", 4, 40);
        for (int b = 0; b < 4; b++) chk_out("t3", b, erec(0, 8'h40, b, b == 3));
        chk("t3_counts", cnt, {32'd5, 32'd4});
        outq.delete(); outc.delete();
        @(negedge aclk);

        // Reset pulse while beat 2 of a 4-beat packet is on the output
        push_pkt(0, 8'h50, 4, -1, 0);
        wait_out("t5_pre", 2, 30);
        aresetn   = 1'b0;
        src_flush = 1'b1;
        @(negedge aclk);
        chk("t5_m_valid", 64'(m_valid), 64'd0);
        chk("t5_s_ready", 64'(s_ready), 64'd0);
        chk("t5_grant",   64'(grant),   64'd0);
        chk("t5_counts",  cnt,          64'd0);
        nlast = 0;
        foreach (outq[i]) if (outq[i][56]) nlast++;
        chk("t5_no_tlast", 64'(nlast), 64'd0);
        src_flush = 1'b0;
        aresetn   = 1'b1;
        outq.delete(); outc.delete();
        @(negedge aclk);
        push_pkt(0, 8'h60, 1, -1, 0);
        push_pkt(1, 8'h61, 1, -1, 0);
        wait_out("t5", 2, 30);
        chk_out("t5", 0, erec(0, 8'h60, 0, 1'b1));
        chk_out("t5", 1, erec(1, 8'h61, 0, 1'b1));
        chk("t5_counts_after", cnt, {32'd1, 32'd1});
        outq.delete(); outc.delete();
        @(negedge aclk);

        // Counter wrap from 0xFFFFFFFF
        force dut.pkt_count_q = {32'd1, 32'hFFFF_FFFF};
        @(negedge aclk);
        release dut.pkt_count_q;
        @(negedge aclk);
        chk("t6_preload", 64'(cnt[31:0]), 64'hFFFF_FFFF);
        push_pkt(0, 8'h70, 1, -1, 0);
        wait_out("t6", 1, 30);
        chk_out("t6", 0, erec(0, 8'h70, 0, 1'b1));
        @(negedge aclk);
        chk("t6_wrap", cnt, {32'd1, 32'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
